// File: rtl/tick_pwm_pkg.sv
// Shared types and default constants for the tick-driven PWM generator.
// Reset period 6 gives a 7-tick PWM cycle; reset duty 3 keeps the output high for 3 of those ticks.
package tick_pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_RST_PERIOD = 6;
    localparam int DEFAULT_RST_DUTY   = 3;

endpackage

// File: rtl/tick_pwm_cfg_shadow.sv
// Single-entry shadow register for PWM period/duty, with a valid/ready offer port.
// The top decides when the shadow may move into the active registers.
module tick_pwm_cfg_shadow
    import tick_pwm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_cfg_valid,
    input  logic [WIDTH-1:0] i_cfg_period,
    input  logic [WIDTH-1:0] i_cfg_duty,
    input  logic             i_load_en,
    output logic             o_cfg_ready,
    output logic             o_load_fire,
    output logic [WIDTH-1:0] o_shadow_period,
    output logic [WIDTH-1:0] o_shadow_duty
);

    // Handshake: a configuration transfers on any clk edge where i_cfg_valid
    // and o_cfg_ready are both 1. ready is simply "shadow empty", so it never
    // depends on valid; valid may be held or dropped freely while ready is 0.
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] shadow_period_q, shadow_period_d;
    logic [WIDTH-1:0] shadow_duty_q, shadow_duty_d;
    logic             xfer;
    logic             fire;

    always_comb begin
        xfer            = i_cfg_valid & ~pending_q;
        fire            = pending_q & i_load_en;
        pending_d       = pending_q;
        shadow_period_d = shadow_period_q;
        shadow_duty_d   = shadow_duty_q;
        // A transfer needs an empty shadow and a load needs a full one, so the two never coincide.
        if (xfer) begin
            pending_d       = 1'b1;
            shadow_period_d = i_cfg_period;
            shadow_duty_d   = i_cfg_duty;
        end else if (fire) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q       <= 1'b0;
            shadow_period_q <= '0;
            shadow_duty_q   <= '0;
        end else begin
            pending_q       <= pending_d;
            shadow_period_q <= shadow_period_d;
            shadow_duty_q   <= shadow_duty_d;
        end
    end

    assign o_cfg_ready     = ~pending_q;
    assign o_load_fire     = fire;
    assign o_shadow_period = shadow_period_q;
    assign o_shadow_duty   = shadow_duty_q;

endmodule

// File: rtl/tick_pwm_gen.sv
// Tick-advanced PWM generator: counts upstream ticks over a cycle of period+1 ticks
// and drives o_pwm high while the count is below the duty value.
module tick_pwm_gen
    import tick_pwm_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int RST_PERIOD = DEFAULT_RST_PERIOD,
    parameter int RST_DUTY   = DEFAULT_RST_DUTY
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_tick,
    input  logic             i_enable,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [WIDTH-1:0] i_cfg_period,
    input  logic [WIDTH-1:0] i_cfg_duty,
    output logic             o_pwm,
    output logic             o_period_end,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] RST_PERIOD_W = WIDTH'(RST_PERIOD);
    localparam logic [WIDTH-1:0] RST_DUTY_W   = WIDTH'(RST_DUTY);
    localparam logic [WIDTH-1:0] CNT_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             period_end_q, period_end_d;

    logic             at_end;
    logic             wrap;
    logic             load_en;
    logic             load_fire;
    logic [WIDTH-1:0] shadow_period;
    logic [WIDTH-1:0] shadow_duty;

    tick_pwm_cfg_shadow #(
        .WIDTH (WIDTH)
    ) u_cfg_shadow (
        .clk             (clk),
        .resetn          (resetn),
        .i_cfg_valid     (i_cfg_valid),
        .i_cfg_period    (i_cfg_period),
        .i_cfg_duty      (i_cfg_duty),
        .i_load_en       (load_en),
        .o_cfg_ready     (o_cfg_ready),
        .o_load_fire     (load_fire),
        .o_shadow_period (shadow_period),
        .o_shadow_duty   (shadow_duty)
    );

    // The shadow may only land where the count is 0 afterwards: a tick-driven wrap or any idle cycle.
    always_comb begin
        at_end  = (count_q == period_q);
        wrap    = (state_q == RUN) && i_enable && i_tick && at_end;
        load_en = (state_q == IDLE) || wrap;
    end

    always_comb begin
        period_d = load_fire ? shadow_period : period_q;
        duty_d   = load_fire ? shadow_duty   : duty_q;
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        pwm_d        = pwm_q;
        period_end_d = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                pwm_d   = 1'b0;
                if (i_enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!i_enable) begin
                    state_d = IDLE;
                    count_d = '0;
                    pwm_d   = 1'b0;
                end else if (i_tick) begin
                    count_d      = at_end ? '0 : count_q + CNT_ONE;
                    period_end_d = at_end;
                    // duty_d already carries a duty loaded on this same wrap.
                    pwm_d        = (count_d < duty_d);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                pwm_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            count_q      <= '0;
            period_q     <= RST_PERIOD_W;
            duty_q       <= RST_DUTY_W;
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    assign o_pwm        = pwm_q;
    assign o_period_end = period_end_q;
    assign o_count      = count_q;

endmodule

// File: doc/tick_pwm_gen.md
TICK_PWM_GEN -- requirements
Module: tick_pwm_gen

Interface
REQ-001 Parameter WIDTH, default 8, width of the period, duty and count fields.
REQ-002 Parameter RST_PERIOD, default 6, active period value loaded at reset; gives 7 ticks per PWM cycle.
REQ-003 Parameter RST_DUTY, default 3, active duty value loaded at reset.
REQ-004 clk  input  1  single clock; all flops rising-edge.
REQ-005 resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 i_tick  input  1  one-cycle advance strobe, driven by the upstream divider's count-end pulse.
REQ-007 i_enable  input  1  level; 1 = run, 0 = hold idle.
REQ-008 i_cfg_valid  input  1  new configuration offered.
REQ-009 o_cfg_ready  output  1  shadow register free; accepts a configuration this cycle.
REQ-010 i_cfg_period  input  WIDTH  new period value P; the PWM cycle is P+1 ticks.
REQ-011 i_cfg_duty  input  WIDTH  new duty value D; o_pwm is high for D ticks per cycle.
REQ-012 o_pwm  output  1  registered PWM output.
REQ-013 o_period_end  output  1  registered one-cycle pulse at each PWM cycle wrap.
REQ-014 o_count  output  WIDTH  current tick position within the PWM cycle.

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN.
- IDLE -> RUN when i_enable=1.
- RUN -> IDLE when i_enable=0; this takes priority over any tick in the same cycle.
REQ-016 In IDLE the block SHALL hold o_count=0, o_pwm=0 and o_period_end=0, and SHALL ignore i_tick.
REQ-017 In RUN, on a cycle with i_tick=1:
- o_count SHALL increment by 1.
- When o_count equals period_active, o_count SHALL instead wrap to 0.
REQ-018 In RUN with i_tick=0, o_count, o_pwm and o_period_end SHALL hold, except o_period_end, which SHALL return to 0.
REQ-019 o_pwm SHALL be updated on the same edge as o_count and SHALL equal (next o_count < duty_active), compared unsigned.
- Duty 0 gives constant low.
- Duty > period gives constant high.
REQ-020 o_period_end SHALL be 1 for exactly the one cycle following a tick-driven wrap to 0.
REQ-021 o_cfg_ready SHALL equal NOT pending. A transfer occurs on i_cfg_valid & o_cfg_ready; it captures period and duty into the shadow register and sets pending.
REQ-022 Shadow-to-active load:
- The shadow SHALL load into the active registers, and pending SHALL clear, on a RUN wrap cycle or on any IDLE cycle.
- In a wrap cycle, o_pwm SHALL use the newly loaded duty.
REQ-023 A transfer in the same cycle as a wrap SHALL NOT load on that wrap; it loads at the next wrap or IDLE cycle.
REQ-024 Period 0 in RUN SHALL wrap on every tick.
- o_period_end pulses after each tick.
- o_pwm = (duty_active > 0).
REQ-025 Deasserting i_enable mid-cycle SHALL force o_count=0 and o_pwm=0 on the next edge, with no o_period_end pulse.
REQ-026 Re-enabling SHALL start the cycle from count 0, with o_pwm computed on the first tick.
REQ-027 All arithmetic SHALL be WIDTH-bit unsigned with no overflow beyond the compare; o_count never exceeds period_active.

Reset
REQ-028 While resetn=0, the block SHALL immediately drive:
- state=IDLE, o_count=0, o_pwm=0, o_period_end=0
- pending=0, o_cfg_ready=1
- period_active=RST_PERIOD, duty_active=RST_DUTY, shadow=0
REQ-029 Release of resetn SHALL be synchronous to clk; first response to i_enable is on the first edge after release.
REQ-030 A reset asserted mid-operation SHALL discard any pending shadow configuration.

Structure
REQ-031 A shared package tick_pwm_pkg SHALL hold:
- the state enum (IDLE, RUN)
- default WIDTH
- the reset period and duty constants
REQ-032 The configuration handshake (shadow register, pending flag, ready) SHALL be one sub-module, tick_pwm_cfg_shadow.
REQ-033 The counter, FSM and output flops SHALL live in the top module.

Verification
REQ-034 Reset defaults, i_enable=1, tick every 7th clk:
- o_pwm is high 3 ticks, low 4 ticks.
- o_period_end pulses once per 7 ticks.
REQ-035 Reconfigure mid-cycle: period=4, duty=2 sent at count 2:
- o_cfg_ready=0 until the wrap.
- The following cycle is 5 ticks with o_pwm high for 2 ticks.
REQ-036 Boundary duty:
- duty=0 gives o_pwm constant 0.
- duty=9 with period=6 gives o_pwm constant 1.
- period=0, duty=1 gives o_pwm=1 and o_period_end after every tick.
REQ-037 i_enable=0 at count 4, re-enable after 10 clks:
- Count 0 and o_pwm=0 the next edge, with no period_end.
- The next cycle restarts at count 0.
REQ-038 Transfer in the same cycle as a wrap:
- The old config runs one more full cycle.
- The new config takes effect at the next wrap.
REQ-039 resetn pulsed low at count 5 with config pending:
- All outputs return to reset values asynchronously.
- The pending config is lost; active returns to 6/3.
